// File: rtl/mux2_bus_arbiter_if.sv
// Handshake and data bundle between two requesters and the shared mux arbiter.
// The requester side drives req/data; the arbiter side returns grants and the registered word.
interface mux2_bus_arbiter_if #(
    parameter int WIDTH = 4
);
    logic             req_a;
    logic             req_b;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             grant_a;
    logic             grant_b;
    logic             select;
    logic [WIDTH-1:0] out;
    logic             out_valid;

    modport master (
        output req_a, req_b, a, b,
        input  grant_a, grant_b, select, out, out_valid
    );

    modport slave (
        input  req_a, req_b, a, b,
        output grant_a, grant_b, select, out, out_valid
    );
endinterface

// File: rtl/mux2_bus_arbiter.sv
// Round-robin arbiter for a shared 2:1 data mux with a hold limit under contention.
// Grants decode from the state register; the selected word is registered onto out.
module mux2_bus_arbiter #(
    parameter int WIDTH    = 4,
    parameter int MAX_HOLD = 4
) (
    input logic              clk,
    input logic              reset,
    mux2_bus_arbiter_if.slave bus
);

    localparam int HW = $clog2(MAX_HOLD) + 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
    localparam logic [HW-1:0] HOLD_SAT  = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             last_b_q, last_b_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             valid_q, valid_d;

    logic ga, gb;
    logic xfer_a, xfer_b;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
            hold_q   <= hold_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_a && bus.req_b)
                    state_d = last_b_q ? GRANT_A : GRANT_B;
                else if (bus.req_a)
                    state_d = GRANT_A;
                else if (bus.req_b)
                    state_d = GRANT_B;
            end
            GRANT_A: begin
                if (!bus.req_a)
                    state_d = bus.req_b ? GRANT_B : IDLE;
                else if (bus.req_b && hold_q == HOLD_LAST)
                    state_d = GRANT_B;
            end
            GRANT_B: begin
                if (!bus.req_b)
                    state_d = bus.req_a ? GRANT_A : IDLE;
                else if (bus.req_a && hold_q == HOLD_LAST)
                    state_d = GRANT_A;
            end
            default: state_d = IDLE;
        endcase
    end

    // Hold counter only advances on contended cycles kept by the same owner
    always_comb begin
        hold_d = '0;
        if (state_d == state_q && bus.req_a && bus.req_b &&
            state_q != IDLE) begin
            hold_d = (hold_q == HOLD_SAT) ? hold_q : hold_q + 1'b1;
        end
    end

    always_comb begin
        last_b_d = last_b_q;
        if (state_d == GRANT_A)
            last_b_d = 1'b0;
        else if (state_d == GRANT_B)
            last_b_d = 1'b1;
    end

    // Output decode
    always_comb begin
        ga = 1'b0;
        gb = 1'b0;
        unique case (state_q)
            GRANT_A: ga = 1'b1;
            GRANT_B: gb = 1'b1;
            default: ;
        endcase
    end

    assign bus.grant_a   = ga;
    assign bus.grant_b   = gb;
    assign bus.select    = gb;
    assign bus.out       = out_q;
    assign bus.out_valid = valid_q;

    assign xfer_a = ga & bus.req_a;
    assign xfer_b = gb & bus.req_b;

    always_comb begin
        out_d   = out_q;
        valid_d = 1'b0;
        if (xfer_a) begin
            out_d   = bus.a;
            valid_d = 1'b1;
        end else if (xfer_b) begin
            out_d   = bus.b;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux2_bus_arbiter.sv
// Bench for mux2_bus_arbiter: directed scenarios plus randomized traffic
// compared each cycle against an owner/streak reference model.
module tb_mux2_bus_arbiter;

    localparam int WIDTH    = 4;
    localparam int MAX_HOLD = 4;

    logic clk;
    logic reset;

    mux2_bus_arbiter_if #(.WIDTH(WIDTH)) bus();

    mux2_bus_arbiter #(
        .WIDTH   (WIDTH),
        .MAX_HOLD(MAX_HOLD)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference model: owner 0 = none, 1 = A, 2 = B
    int             own;
    int             last;
    int             streak;
    logic [WIDTH-1:0] mout;
    bit             mval;
    int             wt_a;
    int             wt_b;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        own    = 0;
        last   = 2;
        streak = 0;
        mout   = '0;
        mval   = 1'b0;
        wt_a   = 0;
        wt_b   = 0;
    endtask

    task automatic model_edge(input bit ra, input bit rb,
                              input logic [WIDTH-1:0] va,
                              input logic [WIDTH-1:0] vb);
        int nxt;
        if (own == 1 && ra) begin
            mout = va;
            mval = 1'b1;
        end else if (own == 2 && rb) begin
            mout = vb;
            mval = 1'b1;
        end else begin
            mval = 1'b0;
        end
        nxt = own;
        if (own == 0) begin
            if (ra && rb)  nxt = (last == 1) ? 2 : 1;
            else if (ra)   nxt = 1;
            else if (rb)   nxt = 2;
        end else begin
            bit mine, other;
            mine  = (own == 1) ? ra : rb;
            other = (own == 1) ? rb : ra;
            if (!mine) begin
                nxt = other ? 3 - own : 0;
            end else if (other) begin
                streak++;
                if (streak >= MAX_HOLD) nxt = 3 - own;
            end else begin
                streak = 0;
            end
        end
        if (nxt != own) streak = 0;
        if (nxt != 0) last = nxt;
        own = nxt;
    endtask

    task automatic step(input bit ra, input bit rb,
                        input logic [WIDTH-1:0] va,
                        input logic [WIDTH-1:0] vb);
        bus.req_a = ra;
        bus.req_b = rb;
        bus.a     = va;
        bus.b     = vb;
        wt_a = (ra && own != 1) ? wt_a + 1 : 0;
        wt_b = (rb && own != 2) ? wt_b + 1 : 0;
        chk("wait_a", 32'(wt_a <= MAX_HOLD + 1), 32'd1);
        chk("wait_b", 32'(wt_b <= MAX_HOLD + 1), 32'd1);
        @(posedge clk);
        model_edge(ra, rb, va, vb);
        #1;
        chk("grant_a", 32'(bus.grant_a), 32'(own == 1));
        chk("grant_b", 32'(bus.grant_b), 32'(own == 2));
        chk("select", 32'(bus.select), 32'(own == 2));
        chk("out_valid", 32'(bus.out_valid), 32'(mval));
        chk("out", 32'(bus.out), 32'(mout));
        chk("mutex", 32'(bus.grant_a & bus.grant_b), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ga"}, 32'(bus.grant_a), 32'd0);
        chk({tag, "_gb"}, 32'(bus.grant_b), 32'd0);
        chk({tag, "_sel"}, 32'(bus.select), 32'd0);
        chk({tag, "_out"}, 32'(bus.out), 32'd0);
        chk({tag, "_val"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Asserted between edges: outputs must clear without a clock
    task automatic mid_reset();
        #2 reset = 1'b1;
        #1 chk_zero("async_rst");
        model_reset();
        #1 reset = 1'b0;
    endtask

    initial begin
        bit ra, rb;
        n_vec     = 0;
        n_err     = 0;
        reset     = 1'b1;
        bus.req_a = 1'b0;
        bus.req_b = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 chk_zero("reset");
        reset = 1'b0;

        step(1, 0, 4'h5, 4'h0);
        step(1, 0, 4'h5, 4'h0);
        mid_reset();
        step(1, 0, 4'h5, 4'h0);
        chk("rst_then_grant", 32'(bus.grant_a), 32'd1);
        chk("rst_then_noval", 32'(bus.out_valid), 32'd0);
        step(1, 0, 4'h5, 4'h0);
        chk("first_word", 32'(bus.out), 32'h5);
        chk("first_valid", 32'(bus.out_valid), 32'd1);

        mid_reset();
        step(1, 1, 4'h3, 4'hC);
        chk("tie_a_first", 32'(bus.select), 32'd0);
        repeat (4) step(1, 1, 4'h3, 4'hC);
        chk("tie_switch_b", 32'(bus.select), 32'd1);
        chk("tie_a_word", 32'(bus.out), 32'h3);
        repeat (4) step(1, 1, 4'h3, 4'hC);
        chk("tie_back_a", 32'(bus.grant_a), 32'd1);
        chk("tie_b_word", 32'(bus.out), 32'hC);

        repeat (10) step(1, 0, 4'($urandom_range(0, 15)), 4'h0);
        chk("uncont_grant", 32'(bus.grant_a), 32'd1);

        step(0, 1, 4'h1, 4'h9);
        chk("drop_noval", 32'(bus.out_valid), 32'd0);
        chk("drop_grant_b", 32'(bus.grant_b), 32'd1);
        step(0, 1, 4'h1, 4'h9);
        chk("handover_word", 32'(bus.out), 32'h9);

        step(0, 0, 4'h0, 4'h0);
        step(0, 0, 4'h0, 4'h0);
        chk("idle_hold_out", 32'(bus.out), 32'h9);

        ra = 1'b0;
        rb = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if ($urandom_range(0, 3) == 0) ra = ~ra;
            if ($urandom_range(0, 3) == 0) rb = ~rb;
            step(ra, rb, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)));
            if (i == 500) mid_reset();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
